// File: rtl/steer_pkg.sv
// steer_pkg: shared constants for the 1-to-2 stream steering stage
package steer_pkg;
  localparam logic SEL_OUT0 = 1'b0;
  localparam logic SEL_OUT1 = 1'b1;
  localparam logic MODE_SEL = 1'b0;
  localparam logic MODE_ALT = 1'b1;
  localparam int STEER_DW = 8;
endpackage

// File: rtl/steer_slot.sv
// steer_slot: one-entry valid/data holding register with load and drain
module steer_slot #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [DW-1:0] d,
  input  logic          ready,
  output logic          valid,
  output logic [DW-1:0] data,
  output logic          free
);
  assign free = ~valid | ready;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
    end else begin
      valid <= load | (valid & ~ready);
      if (load) data <= d;
    end
  end
endmodule

// File: rtl/stream_steer_1to2.sv
// stream_steer_1to2: registered 1-to-2 valid/ready steering stage, explicit or ping-pong target
// STEER_STATS_EN adds cnt_clr/cnt0/cnt1 per-output drain counters
module stream_steer_1to2
  import steer_pkg::*;
#(
  parameter int DW = STEER_DW
`ifdef STEER_STATS_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic          in_sel,
  input  logic          mode,
  output logic          alt_ptr,
  output logic          out0_valid,
  input  logic          out0_ready,
  output logic [DW-1:0] out0_data,
  output logic          out1_valid,
  input  logic          out1_ready,
  output logic [DW-1:0] out1_data
`ifdef STEER_STATS_EN
  ,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
`endif
);
  logic tgt, acc, free0, free1;
  assign tgt = (mode == MODE_ALT) ? alt_ptr : in_sel;
  assign in_ready = (tgt == SEL_OUT1) ? free1 : free0;
  assign acc = in_valid & in_ready;
  steer_slot #(.DW(DW)) u_slot0 (
    .clk(clk), .rst_n(rst_n), .load(acc & (tgt == SEL_OUT0)), .d(in_data),
    .ready(out0_ready), .valid(out0_valid), .data(out0_data), .free(free0)
  );
  steer_slot #(.DW(DW)) u_slot1 (
    .clk(clk), .rst_n(rst_n), .load(acc & (tgt == SEL_OUT1)), .d(in_data),
    .ready(out1_ready), .valid(out1_valid), .data(out1_data), .free(free1)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) alt_ptr <= 1'b0;
    else if (acc && mode == MODE_ALT) alt_ptr <= ~alt_ptr;
  end
`ifdef STEER_STATS_EN
  logic drain0, drain1;
  assign drain0 = out0_valid & out0_ready;
  assign drain1 = out1_valid & out1_ready;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else if (cnt_clr) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      cnt0 <= cnt0 + CNT_W'(drain0);
      cnt1 <= cnt1 + CNT_W'(drain1);
    end
  end
`endif
endmodule

// File: tb/tb_stream_steer_1to2.sv
// tb_stream_steer_1to2: scoreboard bench for stream_steer_1to2 (stats checks when STEER_STATS_EN)
module tb_stream_steer_1to2;
  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid = 1'b0, in_sel = 1'b0, mode = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic out0_ready = 1'b1, out1_ready = 1'b1;
  logic in_ready, alt_ptr, out0_valid, out1_valid;
  logic [7:0] out0_data, out1_data;
`ifdef STEER_STATS_EN
  logic cnt_clr = 1'b0;
  logic [15:0] cnt0, cnt1;
  int m_c0 = 0, m_c1 = 0;
`endif
  int checks = 0, passed = 0;
  logic [7:0] q0[$], q1[$];
  logic m_alt = 1'b0;

  stream_steer_1to2 dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sel(in_sel), .mode(mode), .alt_ptr(alt_ptr),
    .out0_valid(out0_valid), .out0_ready(out0_ready), .out0_data(out0_data),
    .out1_valid(out1_valid), .out1_ready(out1_ready), .out1_data(out1_data)
`ifdef STEER_STATS_EN
    , .cnt_clr(cnt_clr), .cnt0(cnt0), .cnt1(cnt1)
`endif
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: expected words are queued on accept and popped on drain.
  always @(negedge clk) begin
    logic er0, er1, er, t;
    logic [7:0] exp_d;
    if (!rst_n) begin
      q0.delete();
      q1.delete();
      m_alt = 1'b0;
`ifdef STEER_STATS_EN
      m_c0 = 0;
      m_c1 = 0;
`endif
    end else begin
      er0 = (q0.size() == 0) || out0_ready;
      er1 = (q1.size() == 0) || out1_ready;
      checks++;
      if (out0_valid !== (q0.size() != 0)) $display("FAIL sb_valid0 got %b want %b", out0_valid, q0.size() != 0);
      else passed++;
      checks++;
      if (out1_valid !== (q1.size() != 0)) $display("FAIL sb_valid1 got %b want %b", out1_valid, q1.size() != 0);
      else passed++;
      checks++;
      if (alt_ptr !== m_alt) $display("FAIL sb_alt_ptr got %b want %b", alt_ptr, m_alt);
      else passed++;
`ifdef STEER_STATS_EN
      checks++;
      if (cnt0 !== 16'(m_c0) || cnt1 !== 16'(m_c1))
        $display("FAIL sb_counters got %0d/%0d want %0d/%0d", cnt0, cnt1, m_c0, m_c1);
      else passed++;
      if (cnt_clr) begin
        m_c0 = 0;
        m_c1 = 0;
      end else begin
        m_c0 += int'(out0_valid & out0_ready);
        m_c1 += int'(out1_valid & out1_ready);
      end
`endif
      if (out0_valid && out0_ready && q0.size() != 0) begin
        exp_d = q0.pop_front();
        checks++;
        if (out0_data !== exp_d) $display("FAIL sb_data0 got %h want %h", out0_data, exp_d);
        else passed++;
      end
      if (out1_valid && out1_ready && q1.size() != 0) begin
        exp_d = q1.pop_front();
        checks++;
        if (out1_data !== exp_d) $display("FAIL sb_data1 got %h want %h", out1_data, exp_d);
        else passed++;
      end
      t = mode ? m_alt : in_sel;
      er = t ? er1 : er0;
      checks++;
      if (in_ready !== er) $display("FAIL sb_in_ready got %b want %b", in_ready, er);
      else passed++;
      if (in_valid && er) begin
        if (t) q1.push_back(in_data);
        else q0.push_back(in_data);
        if (mode) m_alt = ~m_alt;
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic s, input logic md, output int waits);
    logic r;
    in_valid = 1'b1;
    in_data = d;
    in_sel = s;
    mode = md;
    waits = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      r = in_ready;
      @(posedge clk);
      #1;
      if (r) break;
      waits++;
    end
    if (waits >= 50) begin
      checks++;
      $display("FAIL send_timeout data %h not accepted within 50 cycles", d);
    end
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'($urandom);
      in_data = 8'($urandom);
      in_sel = 1'($urandom);
      mode = 1'($urandom);
      out0_ready = 1'($urandom);
      out1_ready = 1'($urandom);
      @(negedge clk);
      checks++;
      if (out0_valid !== 1'b0 || out1_valid !== 1'b0 || alt_ptr !== 1'b0 || in_ready !== 1'b1)
        $display("FAIL reset_ctrl got v0=%b v1=%b alt=%b rdy=%b want 0 0 0 1", out0_valid, out1_valid, alt_ptr, in_ready);
      else passed++;
      checks++;
      if (out0_data !== 8'h00 || out1_data !== 8'h00)
        $display("FAIL reset_data got %h %h want 00 00", out0_data, out1_data);
      else passed++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    mode = 1'b0;
    rst_n = 1'b1;
    idle(1);
  endtask

  task automatic test_explicit();
    int w;
    send(8'h11, 1'b0, 1'b0, w);
    checks++;
    if (out0_valid !== 1'b1 || out0_data !== 8'h11) $display("FAIL explicit_out0 got %b/%h want 1/11", out0_valid, out0_data);
    else passed++;
    send(8'h22, 1'b1, 1'b0, w);
    checks++;
    if (out1_valid !== 1'b1 || out1_data !== 8'h22) $display("FAIL explicit_out1 got %b/%h want 1/22", out1_valid, out1_data);
    else passed++;
    idle(2);
    checks++;
    if (out0_valid !== 1'b0 || out0_data !== 8'h11) $display("FAIL idle_hold got %b/%h want 0/11", out0_valid, out0_data);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int w, tw = 0;
    for (int i = 0; i < 4; i++) begin
      send(8'hA0 + 8'(i), 1'b0, 1'b1, w);
      tw += w;
    end
    checks++;
    if (tw !== 0) $display("FAIL alt_stream_stall got %0d wait cycles want 0", tw);
    else passed++;
    checks++;
    if (alt_ptr !== 1'b0) $display("FAIL alt_ptr_end got %b want 0", alt_ptr);
    else passed++;
    idle(2);
    send(8'hB0, 1'b0, 1'b1, w);
    send(8'hB1, 1'b0, 1'b0, w);
    mode = 1'b0;
    idle(1);
    checks++;
    if (alt_ptr !== 1'b1) $display("FAIL alt_ptr_hold got %b want 1", alt_ptr);
    else passed++;
    send(8'hB2, 1'b0, 1'b1, w);
    checks++;
    if (out1_valid !== 1'b1 || out1_data !== 8'hB2) $display("FAIL alt_resume got %b/%h want 1/b2", out1_valid, out1_data);
    else passed++;
    mode = 1'b0;
    idle(2);
  endtask

  task automatic test_stall();
    int w;
    out0_ready = 1'b0;
    send(8'h55, 1'b0, 1'b0, w);
    in_valid = 1'b1;
    in_data = 8'h66;
    in_sel = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || out0_valid !== 1'b1 || out0_data !== 8'h55)
        $display("FAIL stall_hold got rdy=%b v=%b d=%h want 0 1 55", in_ready, out0_valid, out0_data);
      else passed++;
    end
    @(posedge clk);
    #1;
    out0_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) $display("FAIL stall_release got rdy=%b want 1", in_ready);
    else passed++;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checks++;
    if (out0_valid !== 1'b1 || out0_data !== 8'h66) $display("FAIL drain_load got %b/%h want 1/66", out0_valid, out0_data);
    else passed++;
    idle(2);
  endtask

  task automatic test_independent();
    int w;
    out1_ready = 1'b0;
    send(8'h77, 1'b1, 1'b0, w);
    send(8'h88, 1'b0, 1'b0, w);
    checks++;
    if (w !== 0 || out0_valid !== 1'b1 || out0_data !== 8'h88 || out1_valid !== 1'b1 || out1_data !== 8'h77)
      $display("FAIL independent got w=%0d out0=%b/%h out1=%b/%h want 0 1/88 1/77", w, out0_valid, out0_data, out1_valid, out1_data);
    else passed++;
    idle(2);
    checks++;
    if (out1_valid !== 1'b1 || out1_data !== 8'h77) $display("FAIL stalled_out1 got %b/%h want 1/77", out1_valid, out1_data);
    else passed++;
    out1_ready = 1'b1;
    idle(2);
  endtask

  task automatic test_midreset();
    int w;
    out1_ready = 1'b0;
    send(8'h99, 1'b1, 1'b0, w);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out1_valid !== 1'b0 || out1_data !== 8'h00) $display("FAIL async_reset got %b/%h want 0/00", out1_valid, out1_data);
    else passed++;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out1_ready = 1'b1;
    idle(2);
  endtask

`ifdef STEER_STATS_EN
  task automatic test_stats();
    int w;
    cnt_clr = 1'b1;
    idle(1);
    cnt_clr = 1'b0;
    send(8'hC0, 1'b0, 1'b0, w);
    send(8'hC1, 1'b0, 1'b0, w);
    send(8'hC2, 1'b0, 1'b0, w);
    send(8'hC3, 1'b1, 1'b0, w);
    idle(2);
    checks++;
    if (cnt0 !== 16'd3 || cnt1 !== 16'd1) $display("FAIL stats_count got %0d/%0d want 3/1", cnt0, cnt1);
    else passed++;
    send(8'hC4, 1'b0, 1'b0, w);
    cnt_clr = 1'b1;
    idle(1);
    cnt_clr = 1'b0;
    checks++;
    if (cnt0 !== 16'd0 || cnt1 !== 16'd0) $display("FAIL stats_clear got %0d/%0d want 0/0", cnt0, cnt1);
    else passed++;
    idle(2);
  endtask
`endif

  initial begin
    test_reset();
    test_explicit();
    test_back_to_back();
    test_stall();
    test_independent();
    test_midreset();
`ifdef STEER_STATS_EN
    test_stats();
`endif
    idle(2);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
